// File: rtl/rect_pkg.sv
// Shared definitions for the Rectilinearizer corner path.
// Holds the calibration FSM state encodings, the 80-bit corner-set packing
// and the default frame dimensions that set the legal corner ranges.
package rect_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_DETECT = 3'd2,
    ST_CHECK  = 3'd3,
    ST_LOAD   = 3'd4,
    ST_FAIL   = 3'd5
  } calib_state_t;

  // Corner packing: {c1x,c1y,c2x,c2y,c3x,c3y,c4x,c4y}, c1x in the MSBs.
  // Corner order is 1=TL, 2=TR, 3=BR, 4=BL.
  localparam int CORNER_W     = 10;
  localparam int NUM_CORNERS  = 4;
  localparam int CORNER_SET_W = 2 * NUM_CORNERS * CORNER_W;

  localparam int C1X_LSB = 70;
  localparam int C1Y_LSB = 60;
  localparam int C2X_LSB = 50;
  localparam int C2Y_LSB = 40;
  localparam int C3X_LSB = 30;
  localparam int C3Y_LSB = 20;
  localparam int C4X_LSB = 10;
  localparam int C4Y_LSB = 0;

  localparam int FRAME_W       = 640;
  localparam int FRAME_H       = 480;
  localparam int DEFAULT_X_MAX = FRAME_W - 1;
  localparam int DEFAULT_Y_MAX = FRAME_H - 1;

  typedef logic [CORNER_W-1:0]     coord_t;
  typedef logic [CORNER_SET_W-1:0] corner_set_t;

  // Field order matches the packing above, so a cast from corner_set_t
  // lands every coordinate in the right member.
  typedef struct packed {
    coord_t c1x;
    coord_t c1y;
    coord_t c2x;
    coord_t c2y;
    coord_t c3x;
    coord_t c3y;
    coord_t c4x;
    coord_t c4y;
  } corner_set_s;

endpackage

// File: rtl/calib_sequencer_if.sv
// Corner-calibration bus: the detector start/done handshake plus the
// corner-adjustment load path (auto_corners / set_corners).
//   master : the sequencer (drives detect_start, auto_corners, set_corners)
//   slave  : detector / corner-adjustment side (drives detect_done, detect_corners)
interface calib_sequencer_if;
  import rect_pkg::*;

  logic        detect_start;
  logic        detect_done;
  corner_set_t detect_corners;
  corner_set_t auto_corners;
  logic        set_corners;

  modport master (
    output detect_start, auto_corners, set_corners,
    input  detect_done, detect_corners
  );

  modport slave (
    input  detect_start, auto_corners, set_corners,
    output detect_done, detect_corners
  );

endinterface

// File: rtl/corner_order_check.sv
// Combinational validity check for a packed corner set.
//   corners : 80-bit {c1x,c1y,c2x,c2y,c3x,c3y,c4x,c4y}
//   x_max   : largest legal x coordinate
//   y_max   : largest legal y coordinate
//   valid   : every coordinate in range and the quad is ordered TL/TR/BR/BL
module corner_order_check
  import rect_pkg::*;
(
  input  corner_set_t corners,
  input  coord_t      x_max,
  input  coord_t      y_max,
  output logic        valid
);

  corner_set_s c;
  logic        in_range;
  logic        ordered;

  assign c = corner_set_s'(corners);

  assign in_range = (c.c1x <= x_max) && (c.c2x <= x_max) &&
                    (c.c3x <= x_max) && (c.c4x <= x_max) &&
                    (c.c1y <= y_max) && (c.c2y <= y_max) &&
                    (c.c3y <= y_max) && (c.c4y <= y_max);

  // Left corners sit left of their right partners; top corners sit above
  // their bottom partners.
  assign ordered = (c.c1x < c.c2x) && (c.c4x < c.c3x) &&
                   (c.c1y < c.c4y) && (c.c2y < c.c3y);

  assign valid = in_range && ordered;

endmodule

// File: rtl/calib_sequencer.sv
// Frame-synchronous corner calibration controller.
// On a start edge it waits for a field edge, launches the corner detector,
// bounds the wait by a frame count, validates the returned set and presents
// it on auto_corners with set_corners held across exactly one field edge.
//   clk, reset   : system clock, synchronous active-high reset
//   field        : frame-sync level, rising edge marks a frame
//   start_button : debounced level, rising edge requests calibration
//   bus          : detector handshake and corner-load outputs (master side)
//   busy         : high whenever the FSM is not idle
//   error        : latched failure, cleared by the next accepted start
//   state_dbg    : current state encoding
module calib_sequencer
  import rect_pkg::*;
#(
  parameter int TIMEOUT_FRAMES = 120,
  parameter int X_MAX          = DEFAULT_X_MAX,
  parameter int Y_MAX          = DEFAULT_Y_MAX
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     field,
  input  logic                     start_button,
  calib_sequencer_if.master        bus,
  output logic                     busy,
  output logic                     error,
  output logic [2:0]               state_dbg
);

  calib_state_t state;
  calib_state_t next_state;

  logic        field_q, field_qq;
  logic        start_q, start_qq;
  logic        field_edge;
  logic        start_edge;
  logic        timeout_hit;
  logic        set_valid;
  logic [7:0]  frame_cnt;
  logic        load_hold;
  logic        error_q;
  corner_set_t capture_q;
  corner_set_t auto_q;
  logic        detect_start_c;
  logic        set_corners_c;

  // Input edge detection on registered copies, so an edge is seen one
  // cycle after the input rises.
  // NOTE: non-blocking assignments make each stage sample the previous
  // stage's pre-edge value; blocking would merge the two stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      field_q  <= 1'b0;
      field_qq <= 1'b0;
      start_q  <= 1'b0;
      start_qq <= 1'b0;
    end else begin
      field_q  <= field;
      field_qq <= field_q;
      start_q  <= start_button;
      start_qq <= start_q;
    end
  end

  assign field_edge = field_q & ~field_qq;
  assign start_edge = start_q & ~start_qq;

  // True when the current field edge is the TIMEOUT_FRAMES-th one in DETECT.
  assign timeout_hit = field_edge &&
                       (({1'b0, frame_cnt} + 9'd1) >= 9'(TIMEOUT_FRAMES));

  corner_order_check u_check (
    .corners (capture_q),
    .x_max   (coord_t'(X_MAX)),
    .y_max   (coord_t'(Y_MAX)),
    .valid   (set_valid)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  // NOTE: next_state gets its default before the case so every path
  // assigns it and no latch is inferred.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:   if (start_edge) next_state = ST_ARM;
      ST_ARM:    if (field_edge) next_state = ST_DETECT;
      ST_DETECT: begin
        // A done in the same cycle as the timeout edge takes priority.
        if (bus.detect_done)  next_state = ST_CHECK;
        else if (timeout_hit) next_state = ST_FAIL;
      end
      ST_CHECK:  next_state = set_valid ? ST_LOAD : ST_FAIL;
      ST_LOAD:   if (load_hold) next_state = ST_IDLE;
      ST_FAIL:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Datapath: frame counter, capture, output corners, load hold, error.
  // NOTE: the capture and output corner registers are reset as well, so
  // auto_corners reads 0 after reset rather than a stale set.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
      capture_q <= '0;
      auto_q    <= '0;
      load_hold <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start_edge) error_q <= 1'b0;
        end
        ST_ARM: begin
          if (field_edge) frame_cnt <= '0;
        end
        ST_DETECT: begin
          if (bus.detect_done) begin
            capture_q <= bus.detect_corners;
          end else if (timeout_hit) begin
            error_q <= 1'b1;
          end
          // Saturating count; only the timeout compare reads it.
          if (field_edge && (frame_cnt != 8'hFF)) frame_cnt <= frame_cnt + 8'd1;
        end
        ST_CHECK: begin
          if (set_valid) auto_q  <= capture_q;
          else           error_q <= 1'b1;
        end
        ST_LOAD: begin
          // Hold set_corners for the edge cycle plus one more.
          if (load_hold)       load_hold <= 1'b0;
          else if (field_edge) load_hold <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Output logic. detect_start is masked by reset so an abort in the
  // launching cycle never fires the detector.
  always_comb begin
    detect_start_c = 1'b0;
    set_corners_c  = 1'b0;
    busy           = 1'b0;
    detect_start_c = (state == ST_ARM) && field_edge && !reset;
    set_corners_c  = (state == ST_LOAD);
    busy           = (state != ST_IDLE);
  end

  assign bus.detect_start = detect_start_c;
  assign bus.set_corners  = set_corners_c;
  assign bus.auto_corners = auto_q;
  assign error            = error_q;
  assign state_dbg        = state;

endmodule

// File: tb/tb_calib_sequencer.sv
module tb_calib_sequencer;
  import rect_pkg::*;

  localparam int TO = 4;
  localparam int XM = 639;
  localparam int YM = 479;

  logic       clk = 1'b0;
  logic       reset;
  logic       field;
  logic       start_button;
  logic       busy;
  logic       error;
  logic [2:0] state_dbg;

  calib_sequencer_if bus_if ();

  calib_sequencer #(.TIMEOUT_FRAMES(TO), .X_MAX(XM), .Y_MAX(YM)) dut (
    .clk          (clk),
    .reset        (reset),
    .field        (field),
    .start_button (start_button),
    .bus          (bus_if),
    .busy         (busy),
    .error        (error),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  // Reference state: the last corner set the design should have accepted.
  logic [79:0] model_auto = '0;

  // Event monitor, sampled on the falling edge.
  int          ds_count, ds_last, sc_count, sc_first, sc_last, err_rise;
  bit          sc_unstable;
  bit          err_prev = 1'b0;
  logic [79:0] sc_val;

  always @(negedge clk) begin
    if (bus_if.detect_start === 1'b1) begin
      ds_count++;
      ds_last = cyc;
    end
    if (bus_if.set_corners === 1'b1) begin
      if (sc_count == 0) begin
        sc_first = cyc;
        sc_val   = bus_if.auto_corners;
      end else if (bus_if.auto_corners !== sc_val) begin
        sc_unstable = 1'b1;
      end
      sc_count++;
      sc_last = cyc;
    end
    if (error === 1'b1 && !err_prev) err_rise = cyc;
    err_prev = (error === 1'b1);
  end

  task automatic clear_mon();
    ds_count = 0; ds_last = -1; sc_count = 0; sc_first = -1; sc_last = -1;
    err_rise = -1; sc_unstable = 1'b0; sc_val = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [79:0] pack(input int a, input int b, input int c, input int d,
                                       input int e, input int f, input int g, input int h);
    return {10'(a), 10'(b), 10'(c), 10'(d), 10'(e), 10'(f), 10'(g), 10'(h)};
  endfunction

  // Validity from the corner rules: ranges, then TL/TR/BR/BL ordering.
  function automatic bit ref_valid(input logic [79:0] c);
    int v[8];
    bit ok;
    for (int i = 0; i < 8; i++) v[i] = int'(c[79-10*i -: 10]);
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if ((i % 2 == 0) && v[i] > XM) ok = 1'b0;
      if ((i % 2 == 1) && v[i] > YM) ok = 1'b0;
    end
    if (!(v[0] < v[2])) ok = 1'b0;  // c1x < c2x
    if (!(v[6] < v[4])) ok = 1'b0;  // c4x < c3x
    if (!(v[1] < v[7])) ok = 1'b0;  // c1y < c4y
    if (!(v[3] < v[5])) ok = 1'b0;  // c2y < c3y
    return ok;
  endfunction

  function automatic logic [79:0] rand_corners();
    int x1, x2, y1, y2, v[8], k;
    logic [79:0] r;
    x1 = $urandom_range(0, 300); x2 = $urandom_range(x1 + 1, XM);
    y1 = $urandom_range(0, 200); y2 = $urandom_range(y1 + 1, YM);
    v = '{x1, y1, x2, y1, x2, y2, x1, y2};
    if ($urandom_range(0, 2) == 0) begin
      k = $urandom_range(0, 7);
      v[k] = $urandom_range(0, 1023);
    end
    r = pack(v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7]);
    return r;
  endfunction

  // One field frame: high two cycles, then low for lo cycles.
  task automatic field_frame(output int rise, input int lo);
    rise  = cyc;
    field = 1'b1;
    tick(); tick();
    field = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic start_and_arm(output int arm_edge);
    int rise;
    start_button = 1'b1;
    tick(); tick();
    checks++; if (state_dbg !== 3'd1) begin errors++; $display("FAIL arm_state got %0d want 1", state_dbg); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL error_clear_on_start got %b want 0", error); end
    start_button = 1'b0;
    field_frame(rise, $urandom_range(2, 4));
    arm_edge = rise + 1;
  endtask

  // Full calibration run: n_edges counted field edges in DETECT before done;
  // with sim set, done coincides with the n_edges-th edge.
  task automatic do_run(input logic [79:0] c, input int n_edges, input bit sim, input bit stray);
    int arm_edge, rise, t, g;
    bit exp_valid;
    exp_valid = ref_valid(c);
    clear_mon();
    start_and_arm(arm_edge);
    if (stray) begin
      start_button = 1'b1; tick(); tick(); start_button = 1'b0; tick();
    end
    for (int i = 0; i < (sim ? n_edges - 1 : n_edges); i++) field_frame(rise, 2);
    if (sim) begin
      field = 1'b1; tick();
    end else begin
      repeat ($urandom_range(0, 2)) tick();
    end
    t = cyc;
    bus_if.detect_done    = 1'b1;
    bus_if.detect_corners = c;
    tick();
    bus_if.detect_done    = 1'b0;
    bus_if.detect_corners = 80'({$urandom(), $urandom(), $urandom()});
    field = 1'b0;
    checks++; if (state_dbg !== 3'd3) begin errors++; $display("FAIL check_state got %0d want 3", state_dbg); end
    g = $urandom_range(2, 5);
    repeat (g - 1) tick();
    field = 1'b1;
    tick(); tick();
    field = 1'b0;
    repeat (4) tick();
    checks++; if (ds_count !== 1) begin errors++; $display("FAIL detect_start_count got %0d want 1", ds_count); end
    checks++; if (ds_last !== arm_edge) begin errors++; $display("FAIL detect_start_cycle got %0d want %0d", ds_last, arm_edge); end
    if (exp_valid) begin
      checks++; if (sc_first !== t + 2) begin errors++; $display("FAIL set_rise got %0d want %0d", sc_first, t + 2); end
      checks++; if (sc_last !== t + g + 2) begin errors++; $display("FAIL set_fall got %0d want %0d", sc_last, t + g + 2); end
      checks++; if (sc_count !== g + 1) begin errors++; $display("FAIL set_len got %0d want %0d", sc_count, g + 1); end
      checks++; if (sc_val !== c) begin errors++; $display("FAIL load_value got %h want %h", sc_val, c); end
      checks++; if (sc_unstable !== 1'b0) begin errors++; $display("FAIL load_stable got %b want 0", sc_unstable); end
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL ok_error got %b want 0", error); end
      model_auto = c;
    end else begin
      checks++; if (sc_count !== 0) begin errors++; $display("FAIL bad_set_strobe got %0d want 0", sc_count); end
      checks++; if (error !== 1'b1) begin errors++; $display("FAIL bad_error got %b want 1", error); end
      checks++; if (err_rise !== t + 2) begin errors++; $display("FAIL bad_error_cycle got %0d want %0d", err_rise, t + 2); end
    end
    checks++; if (bus_if.auto_corners !== model_auto) begin errors++; $display("FAIL auto_corners got %h want %h", bus_if.auto_corners, model_auto); end
    checks++; if (busy !== 1'b0 || state_dbg !== 3'd0) begin errors++; $display("FAIL back_to_idle got busy=%b st=%0d want 0/0", busy, state_dbg); end
  endtask

  task automatic test_reset();
    reset = 1'b1; field = 1'b0; start_button = 1'b0;
    bus_if.detect_done = 1'b0; bus_if.detect_corners = '0;
    clear_mon();
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checks++; if (state_dbg !== 3'd0) begin errors++; $display("FAIL rst_state got %0d want 0", state_dbg); end
    checks++; if (busy !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL rst_flags got busy=%b err=%b want 0/0", busy, error); end
    checks++; if (bus_if.detect_start !== 1'b0 || bus_if.set_corners !== 1'b0) begin errors++; $display("FAIL rst_strobes got ds=%b sc=%b want 0/0", bus_if.detect_start, bus_if.set_corners); end
    checks++; if (bus_if.auto_corners !== 80'd0) begin errors++; $display("FAIL rst_auto got %h want 0", bus_if.auto_corners); end
  endtask

  task automatic test_normal();
    do_run(pack(100, 80, 540, 80, 540, 400, 100, 400), 3, 1'b0, 1'b0);
  endtask

  task automatic test_invalid();
    do_run(pack(600, 80, 500, 80, 540, 400, 100, 400), 1, 1'b0, 1'b0);
    do_run(pack(100, 80, 540, 80, 540, 400, 100, 500), 2, 1'b0, 1'b0);
    do_run(pack(0, 0, 639, 0, 639, 479, 0, 479), 0, 1'b0, 1'b0);   // exactly at the limits
    do_run(pack(0, 0, 640, 0, 639, 479, 0, 479), 1, 1'b0, 1'b0);   // one past X_MAX
  endtask

  task automatic test_simultaneous();
    do_run(pack(120, 90, 500, 70, 520, 410, 90, 420), TO, 1'b1, 1'b0);
  endtask

  task automatic test_timeout();
    int arm_edge, rise;
    clear_mon();
    start_and_arm(arm_edge);
    for (int i = 0; i < TO; i++) field_frame(rise, 3);
    repeat (3) tick();
    checks++; if (err_rise !== rise + 2) begin errors++; $display("FAIL timeout_cycle got %0d want %0d", err_rise, rise + 2); end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL timeout_error got %b want 1", error); end
    checks++; if (sc_count !== 0) begin errors++; $display("FAIL timeout_strobe got %0d want 0", sc_count); end
    checks++; if (ds_count !== 1) begin errors++; $display("FAIL timeout_ds_count got %0d want 1", ds_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_idle got %b want 0", busy); end
    checks++; if (bus_if.auto_corners !== model_auto) begin errors++; $display("FAIL timeout_auto got %h want %h", bus_if.auto_corners, model_auto); end
  endtask

  task automatic test_stray();
    clear_mon();
    bus_if.detect_done    = 1'b1;
    bus_if.detect_corners = pack(10, 10, 20, 10, 20, 20, 10, 20);
    tick();
    bus_if.detect_done = 1'b0;
    repeat (3) tick();
    checks++; if (busy !== 1'b0 || ds_count !== 0 || sc_count !== 0) begin errors++; $display("FAIL stray_done got busy=%b ds=%0d sc=%0d want 0/0/0", busy, ds_count, sc_count); end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL stray_error_kept got %b want 1", error); end
    checks++; if (bus_if.auto_corners !== model_auto) begin errors++; $display("FAIL stray_auto got %h want %h", bus_if.auto_corners, model_auto); end
    do_run(pack(50, 40, 600, 30, 610, 450, 40, 460), 2, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    bit sim;
    for (int r = 0; r < 8; r++) begin
      sim = 1'($urandom_range(0, 1));
      do_run(rand_corners(), sim ? int'($urandom_range(1, TO)) : int'($urandom_range(0, TO - 1)), sim, 1'b0);
    end
  endtask

  task automatic test_reset_during_load();
    int arm_edge, rise;
    logic [79:0] c;
    c = pack(30, 20, 610, 25, 600, 460, 35, 450);
    clear_mon();
    start_and_arm(arm_edge);
    field_frame(rise, 2);
    bus_if.detect_done = 1'b1; bus_if.detect_corners = c;
    tick();
    bus_if.detect_done = 1'b0;
    tick();
    checks++; if (bus_if.set_corners !== 1'b1) begin errors++; $display("FAIL rl_set_high got %b want 1", bus_if.set_corners); end
    reset = 1'b1;
    tick();
    checks++; if (bus_if.set_corners !== 1'b0 || bus_if.detect_start !== 1'b0) begin errors++; $display("FAIL rl_strobes got sc=%b ds=%b want 0/0", bus_if.set_corners, bus_if.detect_start); end
    checks++; if (busy !== 1'b0 || error !== 1'b0 || state_dbg !== 3'd0) begin errors++; $display("FAIL rl_state got busy=%b err=%b st=%0d want 0/0/0", busy, error, state_dbg); end
    checks++; if (bus_if.auto_corners !== 80'd0) begin errors++; $display("FAIL rl_auto got %h want 0", bus_if.auto_corners); end
    reset = 1'b0;
    model_auto = '0;
    clear_mon();
    tick();
    bus_if.detect_done = 1'b1;
    tick();
    bus_if.detect_done = 1'b0;
    repeat (4) tick();
    checks++; if (busy !== 1'b0 || sc_count !== 0 || ds_count !== 0) begin errors++; $display("FAIL rl_late_done got busy=%b sc=%0d ds=%0d want 0/0/0", busy, sc_count, ds_count); end
    checks++; if (bus_if.auto_corners !== model_auto) begin errors++; $display("FAIL rl_late_auto got %h want %h", bus_if.auto_corners, model_auto); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_invalid();
    test_simultaneous();
    test_timeout();
    test_stray();
    test_back_to_back();
    test_reset_during_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/calib_sequencer.md
# calib_sequencer

Frame-synchronous controller for the corner calibration step of the Rectilinearizer. On a start request it waits for a frame boundary, triggers the automatic corner detector with a start/done handshake, and bounds the wait with a frame-count timeout. It validates the returned corner set, then drives the `auto_corners` and `set_corners` inputs of the corner-adjustment interface so the whole set loads on exactly one field edge.

## Interface
- `TIMEOUT_FRAMES`, default 120: field edges allowed in DETECT before failure; range 1–255.
- `X_MAX`, default 639: largest legal corner x.
- `Y_MAX`, default 479: largest legal corner y.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `field`  in  1  frame-sync level; its rising edge marks a frame.
- `start_button`  in  1  debounced level; its rising edge requests calibration.
- `detect_start`  out  1  one-cycle pulse that launches the detector.
- `detect_done`  in  1  one-cycle pulse; `detect_corners` is valid in the same cycle.
- `detect_corners`  in  80  packed `{c1x,c1y,c2x,c2y,c3x,c3y,c4x,c4y}`, 10 bits each, c1x at [79:70].
- `auto_corners`  out  80  registered copy of the last accepted corner set, same packing.
- `set_corners`  out  1  load strobe held across one field edge.
- `busy`  out  1  high in any state other than IDLE.
- `error`  out  1  latched failure flag.
- `state_dbg`  out  3  current state encoding, for hex display.

## Operation
- States and transitions:
  - IDLE: start edge → ARM.
  - ARM: field edge → DETECT, pulsing `detect_start` in that cycle and clearing the frame counter.
  - DETECT:
    - `detect_done` → CHECK, latching `detect_corners` into a capture register.
    - Otherwise each field edge increments the frame counter; reaching `TIMEOUT_FRAMES` → FAIL.
  - CHECK (1 cycle):
    - If valid: → LOAD, copy the capture register to `auto_corners`.
    - If invalid: → FAIL.
  - LOAD: `set_corners` is high. After a field edge it stays high one more cycle, then → IDLE.
  - FAIL: `error` is set → IDLE.
- Validity requires all of the following (unsigned 10-bit compares; corner order 1=TL, 2=TR, 3=BR, 4=BL):
  - every x ≤ `X_MAX` and every y ≤ `Y_MAX`;
  - c1x < c2x, c4x < c3x, c1y < c4y, c2y < c3y.
- `error` clears on the next accepted start edge.
- Start edges outside IDLE are ignored.
- `detect_done` outside DETECT is ignored.
- If `detect_done` and the timeout field edge arrive in the same cycle, done wins.
- The frame counter is 8 bits and saturates; it never wraps.

## Timing
- Reset values: state IDLE; `detect_start`=0, `set_corners`=0, `busy`=0, `error`=0, `auto_corners`=0, `state_dbg`=0. Capture register and counter are 0.
- Reset mid-operation aborts immediately with no further `detect_start` or `set_corners`. A detector done arriving afterwards is ignored.
- Edge detection uses registered `field` and `start_button`. An edge is seen 1 cycle after the input rises.
- `detect_start` is high exactly 1 cycle: the ARM cycle that sees the field edge.
- `detect_done` at cycle t gives:
  - CHECK at t+1;
  - `auto_corners` updated and `set_corners`=1 at t+2.
- `set_corners` stays high through the cycle a field edge is seen and the following cycle, then falls. `auto_corners` is stable for that entire window. A consumer sampling on its own registered field edge therefore loads exactly once.
- Timeout occurs on the `TIMEOUT_FRAMES`-th field edge counted in DETECT. `error` rises 1 cycle later.

## Structure
- Shared package `rect_pkg` holds:
  - state encodings IDLE=0, ARM=1, DETECT=2, CHECK=3, LOAD=4, FAIL=5;
  - corner field widths and slice offsets for the 80-bit packing;
  - default frame dimensions.
- One combinational sub-module, `corner_order_check`. It takes the 80-bit set plus `X_MAX`/`Y_MAX` and outputs `valid`. It is reused by any later module that accepts manual corners.

## Test plan
- Normal run:
  - Stimulus: start edge, field edge, then done 3 frames later with corners (100,80),(540,80),(540,400),(100,400).
  - Response: one `detect_start` pulse; `set_corners` high 2 cycles after done, held through the next field edge +1; `auto_corners`=packed input; `error`=0.
- Timeout:
  - Stimulus: `TIMEOUT_FRAMES`=4, no done.
  - Response: FAIL after the 4th field edge in DETECT; `error`=1; `set_corners` never rises; return to IDLE.
- Invalid set:
  - Stimulus: c1x=600, c2x=500, or any y=500.
  - Response: `error`=1; `auto_corners` unchanged from the previous value.
- Simultaneous:
  - Stimulus: done coincident with the 4th field edge.
  - Response: done accepted; no error.
- Reset during LOAD:
  - Stimulus: assert `reset` while `set_corners`=1.
  - Response: `set_corners`=0 next cycle; all outputs at reset values.
- Stray inputs:
  - Stimulus: a second start during DETECT, and a done in IDLE.
  - Response: both ignored; exactly one `detect_start` per run.
